hazard_flush_ctrl: RTL and testbench
====================================

HAZARD_FLUSH_CTRL -- requirements
Module: hazard_flush_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the stall and flush event counters.
REQ-002 clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 IDRs  in  5  rs field of the instruction in ID.
REQ-005 IDRt  in  5  rt field of the instruction in ID.
REQ-006 IDUsesRt  in  1  the ID instruction reads rt as a source.
REQ-007 EXMemRead  in  1  MemRead output of the ID/EX register (load in EX).
REQ-008 EXRt  in  5  RtReg output of the ID/EX register (load destination).
REQ-009 BranchTaken  in  1  branch in EX resolved taken this cycle.
REQ-010 JumpID  in  1  jump or jal decoded in ID this cycle.
REQ-011 PCWrite  out  1  PC update enable.
REQ-012 IFIDWrite  out  1  IF/ID register load enable.
REQ-013 IFIDFlush  out  1  zero the IF/ID register at the next edge.
REQ-014 IDEXFlush  out  1  drives the ID/EX register flush input.
REQ-015 HzState  out  2  current FSM state, for debug.
REQ-016 StallCount  out  CNT_W  number of load-use stalls since reset.
REQ-017 FlushCount  out  CNT_W  number of control-flow flush events since reset.

Function
REQ-018 loadUse SHALL be EXMemRead and (EXRt != 0) and (EXRt == IDRs or (IDUsesRt and EXRt == IDRt)).
REQ-019 The FSM SHALL have three states: RUN=0, STALL=1, FLUSH=2; encoding 3 is illegal and SHALL return to RUN at the next edge with all outputs at their RUN pass values.
REQ-020 PCWrite, IFIDWrite, IFIDFlush and IDEXFlush SHALL be combinational from state and inputs; their effect appears at the same rising edge, with zero added latency.
REQ-021 Pass values SHALL be PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXFlush=0.
REQ-022 RUN, priority 1: if BranchTaken, assert IFIDFlush=1 and IDEXFlush=1 with PCWrite=1, go to FLUSH, and increment FlushCount.
REQ-023 RUN, priority 2: else if loadUse, drive PCWrite=0, IFIDWrite=0, IDEXFlush=1, go to STALL, and increment StallCount.
REQ-024 RUN, priority 3: else if JumpID, drive IFIDFlush=1, stay in RUN, and increment FlushCount.
REQ-025 RUN otherwise: drive pass values and stay in RUN.
REQ-026 STALL SHALL last exactly one cycle: loadUse is ignored, BranchTaken and JumpID are handled as in RUN, and the state goes to FLUSH if BranchTaken, else RUN.
REQ-027 FLUSH SHALL last exactly one cycle: JumpID and loadUse are ignored, BranchTaken is handled as in RUN (back-to-back flush stays in FLUSH), and the state goes to RUN otherwise.
REQ-028 Simultaneous BranchTaken and loadUse SHALL produce the branch action only; StallCount is unchanged.
REQ-029 Simultaneous BranchTaken and JumpID SHALL increment FlushCount by exactly 1.
REQ-030 Counters SHALL wrap from 2^CNT_W-1 to 0 without saturation or flag.

Reset
REQ-031 While rst_n=0 at an edge, state becomes RUN and both counters become 0.
REQ-032 While rst_n=0, outputs SHALL be PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1, regardless of state or inputs.
REQ-033 Reset asserted in STALL or FLUSH SHALL abort that state; the first cycle after release is RUN.

Structure
REQ-034 State encodings (RUN, STALL, FLUSH) and CNT_W default SHALL live in shared package cpu_pkg.
REQ-035 One sub-module, hz_event_counter (CNT_W-bit enable-increment wrap counter with synchronous active-low clear), SHALL be instantiated twice.
REQ-036 No other sub-modules; the FSM and loadUse compare are inline.

Verification
REQ-037 Apply EXMemRead=1, EXRt=5, IDRs=5 in RUN -> PCWrite=0, IFIDWrite=0, IDEXFlush=1 that cycle; next cycle STALL with pass values; StallCount=1.
REQ-038 Apply EXMemRead=1, EXRt=0, IDRs=0 -> no stall and StallCount stays 0; repeat with EXRt=7, IDRt=7, IDUsesRt=0 -> no stall.
REQ-039 Apply BranchTaken=1 together with loadUse in RUN -> IFIDFlush=1, IDEXFlush=1, PCWrite=1, next state FLUSH, FlushCount+1, StallCount unchanged.
REQ-040 Apply JumpID=1 in RUN, then JumpID=1 in the cycle after BranchTaken (FLUSH) -> first gives IFIDFlush=1 and FlushCount+1; second is ignored.
REQ-041 Drive rst_n=0 during STALL -> outputs 0/0/1/1 while low; counters 0 and HzState=RUN on the first cycle after release.
REQ-042 Preload StallCount to 2^CNT_W-1 using 65535 stalls, then one more stall -> StallCount=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: hazard FSM state encoding and the
// default width of the hazard event counters.
package cpu_pkg;

   localparam int CNT_W_DEF = 16;

   // Encoding 2'd3 is unused; the FSM recovers from it to RUN.
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } hzState_t;

endpackage

// File: rtl/hz_event_counter.sv
// Free-running event counter: increments on inc, wraps silently at
// 2^CNT_W-1 -> 0, synchronous active-low clear has priority.
module hz_event_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clrN,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count register: clear first, then enable-increment with natural wrap.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (!clrN) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard / flush controller: detects load-use hazards, sequences
// one-cycle stalls and control-flow flushes, and counts both event kinds.
module hazard_flush_ctrl
   import cpu_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       IDRs,
   input  logic [4:0]       IDRt,
   input  logic             IDUsesRt,
   input  logic             EXMemRead,
   input  logic [4:0]       EXRt,
   input  logic             BranchTaken,
   input  logic             JumpID,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IFIDFlush,
   output logic             IDEXFlush,
   output logic [1:0]       HzState,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   hzState_t state;
   hzState_t nextState;
   logic     loadUse;
   logic     stallInc;
   logic     flushInc;

   // Load in EX writes a register the ID instruction is about to read.
   always_comb begin
      loadUse = EXMemRead && (EXRt != 5'd0) &&
                ((EXRt == IDRs) || (IDUsesRt && (EXRt == IDRt)));
   end

   // State register; reset aborts any stall or flush in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= nextState;
      end
   end

   // Next state, pipeline controls and counter enables; priority is
   // taken branch, then load-use, then jump.
   always_comb begin
      // NOTE: every output gets a default before any branch so no path
      // leaves a signal unassigned and no latch is inferred.
      nextState = RUN;
      PCWrite   = 1'b1;
      IFIDWrite = 1'b1;
      IFIDFlush = 1'b0;
      IDEXFlush = 1'b0;
      stallInc  = 1'b0;
      flushInc  = 1'b0;

      if (!rst_n) begin
         PCWrite   = 1'b0;
         IFIDWrite = 1'b0;
         IFIDFlush = 1'b1;
         IDEXFlush = 1'b1;
      end else begin
         unique case (state)
            RUN, STALL, FLUSH: begin
               if (BranchTaken) begin
                  IFIDFlush = 1'b1;
                  IDEXFlush = 1'b1;
                  flushInc  = 1'b1;
                  nextState = FLUSH;
               end else if (loadUse && (state == RUN)) begin
                  PCWrite   = 1'b0;
                  IFIDWrite = 1'b0;
                  IDEXFlush = 1'b1;
                  stallInc  = 1'b1;
                  nextState = STALL;
               end else if (JumpID && (state != FLUSH)) begin
                  IFIDFlush = 1'b1;
                  flushInc  = 1'b1;
               end
            end
            default: begin
               // Illegal encoding: pass values, back to RUN.
            end
         endcase
      end
   end

   assign HzState = state;

   hz_event_counter #(.CNT_W(CNT_W)) uStallCounter (
      .clk   (clk),
      .clrN  (rst_n),
      .inc   (stallInc),
      .count (StallCount)
   );

   hz_event_counter #(.CNT_W(CNT_W)) uFlushCounter (
      .clk   (clk),
      .clrN  (rst_n),
      .inc   (flushInc),
      .count (FlushCount)
   );

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl: directed scenarios plus
// randomized traffic compared against a behavioural reference model.
module tb_hazard_flush_ctrl;

   // Narrow counters keep the wrap-around scenario short.
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       IDRs;
   logic [4:0]       IDRt;
   logic             IDUsesRt;
   logic             EXMemRead;
   logic [4:0]       EXRt;
   logic             BranchTaken;
   logic             JumpID;
   logic             PCWrite;
   logic             IFIDWrite;
   logic             IFIDFlush;
   logic             IDEXFlush;
   logic [1:0]       HzState;
   logic [CNT_W-1:0] StallCount;
   logic [CNT_W-1:0] FlushCount;

   int passCount  = 0;
   int checkCount = 0;

   // Reference model: what the previous cycle did (0 nothing special,
   // 1 started a stall, 2 took a branch) and the two event totals.
   int mPrev  = 0;
   int mStall = 0;
   int mFlush = 0;
   int mMask  = (1 << CNT_W) - 1;

   hazard_flush_ctrl #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .IDRs        (IDRs),
      .IDRt        (IDRt),
      .IDUsesRt    (IDUsesRt),
      .EXMemRead   (EXMemRead),
      .EXRt        (EXRt),
      .BranchTaken (BranchTaken),
      .JumpID      (JumpID),
      .PCWrite     (PCWrite),
      .IFIDWrite   (IFIDWrite),
      .IFIDFlush   (IFIDFlush),
      .IDEXFlush   (IDEXFlush),
      .HzState     (HzState),
      .StallCount  (StallCount),
      .FlushCount  (FlushCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs === exp) begin
         passCount++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One cycle: drive at the falling edge, check just after, then advance
   // the model to what the next rising edge should produce.
   task automatic step(input bit rstn, input bit br, input bit jmp, input bit mr,
                       input bit usesRt, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] exrt);
      bit lu;
      int ePc, eIfw, eIff, eIdf;
      @(negedge clk);
      rst_n       = rstn;
      BranchTaken = br;
      JumpID      = jmp;
      EXMemRead   = mr;
      IDUsesRt    = usesRt;
      IDRs        = rs;
      IDRt        = rt;
      EXRt        = exrt;
      #1;
      lu = mr && (exrt != 0) && ((exrt == rs) || (usesRt && (exrt == rt)));

      // Registered view first: state and totals from previous edges.
      check("hz_state",    32'(HzState),    32'(mPrev));
      check("stall_count", 32'(StallCount), 32'(mStall));
      check("flush_count", 32'(FlushCount), 32'(mFlush));

      if (!rstn) begin
         {ePc, eIfw, eIff, eIdf} = {32'd0, 32'd0, 32'd1, 32'd1};
         mPrev = 0; mStall = 0; mFlush = 0;
      end else if (br) begin
         {ePc, eIfw, eIff, eIdf} = {32'd1, 32'd1, 32'd1, 32'd1};
         mPrev = 2; mFlush++;
      end else if (mPrev == 2) begin
         {ePc, eIfw, eIff, eIdf} = {32'd1, 32'd1, 32'd0, 32'd0};
         mPrev = 0;
      end else if (lu && mPrev != 1) begin
         {ePc, eIfw, eIff, eIdf} = {32'd0, 32'd0, 32'd0, 32'd1};
         mPrev = 1; mStall++;
      end else if (jmp) begin
         {ePc, eIfw, eIff, eIdf} = {32'd1, 32'd1, 32'd1, 32'd0};
         mPrev = 0; mFlush++;
      end else begin
         {ePc, eIfw, eIff, eIdf} = {32'd1, 32'd1, 32'd0, 32'd0};
         mPrev = 0;
      end
      mStall &= mMask;
      mFlush &= mMask;

      check("pc_write",    32'(PCWrite),   32'(ePc));
      check("ifid_write",  32'(IFIDWrite), 32'(eIfw));
      check("ifid_flush",  32'(IFIDFlush), 32'(eIff));
      check("idex_flush",  32'(IDEXFlush), 32'(eIdf));
   endtask

   task automatic idle();
      step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
   endtask

   initial begin
      rst_n = 1'b0; IDRs = '0; IDRt = '0; IDUsesRt = 1'b0; EXMemRead = 1'b0;
      EXRt = '0; BranchTaken = 1'b0; JumpID = 1'b0;

      // Reset
      step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      step(0, 1, 1, 1, 1, 5'd3, 5'd3, 5'd3);
      idle();

      // Load-use on rs, then the one-cycle STALL
      step(1, 0, 0, 1, 0, 5'd5, 5'd0, 5'd5);
      idle();
      check("stall_after_first_loaduse", 32'(StallCount), 32'd1);
      idle();

      // No hazard for $0, nor for rt when rt is not a source
      step(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
      step(1, 0, 0, 1, 0, 5'd3, 5'd7, 5'd7);
      // rt hazard when rt is a source
      step(1, 0, 0, 1, 1, 5'd3, 5'd7, 5'd7);
      idle();

      // Branch with load-use: branch wins
      step(1, 1, 0, 1, 0, 5'd5, 5'd0, 5'd5);
      idle();

      // Jump in RUN counts; jump right after a branch is ignored
      step(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      step(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      // Branch + jump together count once; back-to-back branches
      step(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      idle();

      // Stall then jump in STALL is honoured
      step(1, 0, 0, 1, 0, 5'd9, 5'd0, 5'd9);
      step(1, 0, 1, 1, 0, 5'd9, 5'd0, 5'd9);
      idle();

      // Reset during STALL
      step(1, 0, 0, 1, 0, 5'd4, 5'd0, 5'd4);
      step(0, 0, 0, 1, 0, 5'd4, 5'd0, 5'd4);
      step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      idle();
      check("state_after_reset_release", 32'(HzState), 32'd0);

      // Randomized traffic on a small register range to provoke matches
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(99) != 0, $urandom_range(4) == 0, $urandom_range(4) == 0,
              $urandom_range(1) == 1, $urandom_range(1) == 1,
              5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
      end

      // Counter wrap: 2^CNT_W-1 stalls, then one more
      step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
         step(1, 0, 0, 1, 0, 5'd6, 5'd0, 5'd6);
         idle();
      end
      check("stall_count_at_max", 32'(StallCount), 32'((1 << CNT_W) - 1));
      step(1, 0, 0, 1, 0, 5'd6, 5'd0, 5'd6);
      idle();
      check("stall_count_wrapped", 32'(StallCount), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
